demux_1to2_stream: RTL and testbench

//  Routes one valid/ready input stream to one of two output streams, chosen per beat by in_sel.

---
 rtl/demux_pkg.sv | 11 +
 rtl/stream_reg_slice.sv | 33 +++
 rtl/demux_1to2_stream.sv | 79 +++++++
 tb/tb_demux_1to2_stream.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and constants for the 1:2 valid/ready stream demultiplexer.
package demux_pkg;

    typedef enum logic {
        SEL_OUT0 = 1'b0,
        SEL_OUT1 = 1'b1
    } demux_sel_e;

    localparam int DEMUX_N_OUT = 2;

endpackage

// File: rtl/stream_reg_slice.sv
// One-entry valid/ready register: holds a beat until the consumer takes it,
// and can be reloaded in the same cycle it drains for full throughput.
module stream_reg_slice
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              can_load,
    output logic              valid,
    input  logic              ready,
    output logic [DATA_W-1:0] data
);

    assign can_load = !valid || ready;

    // A load wins over a drain, so a beat arriving as the old one leaves keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1to2_stream.sv
// Routes one valid/ready stream to one of two registered outputs per beat,
// with a saturating delivered-beat counter on each output.
module demux_1to2_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    demux_sel_e                                sel;
    logic [DEMUX_N_OUT-1:0]                    load;
    logic [DEMUX_N_OUT-1:0]                    can_load;
    logic [DEMUX_N_OUT-1:0]                    valid;
    logic [DEMUX_N_OUT-1:0]                    ready;
    logic [DEMUX_N_OUT-1:0][DATA_W-1:0]        data;
    logic [DEMUX_N_OUT-1:0][CNT_W-1:0]         cnt;

    assign sel   = demux_sel_e'(in_sel);
    assign ready = {out1_ready, out0_ready};

    assign in_ready = (sel == SEL_OUT1) ? can_load[1] : can_load[0];

    // in_valid gates every load term, so an unknown in_sel while idle cannot reach the slices.
    assign load[0] = in_valid && in_ready && (sel == SEL_OUT0);
    assign load[1] = in_valid && in_ready && (sel == SEL_OUT1);

    for (genvar n = 0; n < DEMUX_N_OUT; n++) begin : g_out
        logic [CNT_W-1:0] cnt_q;

        stream_reg_slice #(
            .DATA_W (DATA_W)
        ) u_slice (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[n]),
            .load_data (in_data),
            .can_load  (can_load[n]),
            .valid     (valid[n]),
            .ready     (ready[n]),
            .data      (data[n])
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (clr_cnt) begin
                cnt_q <= '0;
            end else if (valid[n] && ready[n] && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign cnt[n] = cnt_q;
    end

    assign out0_valid = valid[0];
    assign out0_data  = data[0];
    assign out1_valid = valid[1];
    assign out1_data  = data[1];
    assign cnt0       = cnt[0];
    assign cnt1       = cnt[1];

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Bench for demux_1to2_stream: a wide-counter and a 4-bit-counter instance share
// stimulus; a queue-per-output model checks every cycle alongside directed tables.
module tb_demux_1to2_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sel = 1'b0;
    logic [7:0] in_data = '0;
    logic       r0 = 1'b0;
    logic       r1 = 1'b0;
    logic       clr_cnt = 1'b0;

    logic        in_ready, o0v, o1v;
    logic [7:0]  o0d, o1d;
    logic [15:0] cnt0, cnt1;

    logic        in_ready_s, o0v_s, o1v_s;
    logic [7:0]  o0d_s, o1d_s;
    logic [3:0]  cnt0_s, cnt1_s;

    always #5 clk = ~clk;

    demux_1to2_stream #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel),
        .out0_valid(o0v), .out0_ready(r0), .out0_data(o0d),
        .out1_valid(o1v), .out1_ready(r1), .out1_data(o1d),
        .clr_cnt(clr_cnt), .cnt0(cnt0), .cnt1(cnt1)
    );

    demux_1to2_stream #(.DATA_W(8), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_sel(in_sel),
        .out0_valid(o0v_s), .out0_ready(r0), .out0_data(o0d_s),
        .out1_valid(o1v_s), .out1_ready(r1), .out1_data(o1d_s),
        .clr_cnt(clr_cnt), .cnt0(cnt0_s), .cnt1(cnt1_s)
    );

    int checks = 0;
    int errors = 0;

    // Reference: each output is a FIFO of beats not yet delivered; counters are plain integers.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int m0 = 0, m1 = 0, s0 = 0, s1 = 0;

    typedef struct {
        logic       v;
        logic       sel;
        logic [7:0] d;
        logic       rr0;
        logic       rr1;
        logic       ir;
        logic       ov0;
        logic [7:0] od0;
        logic       ov1;
        logic [7:0] od1;
        int         c0;
        int         c1;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_ready();
        if (in_sel) return (q1.size() == 0) || r1;
        return (q0.size() == 0) || r0;
    endfunction

    task automatic model_check();
        logic er;
        er = exp_ready();
        chk("in_ready", {31'd0, in_ready}, {31'd0, er});
        chk("in_ready_s", {31'd0, in_ready_s}, {31'd0, er});
        chk("out0_valid", {31'd0, o0v}, {31'd0, q0.size() != 0});
        if (q0.size() != 0) chk("out0_data", {24'd0, o0d}, {24'd0, q0[0]});
        chk("out1_valid", {31'd0, o1v}, {31'd0, q1.size() != 0});
        if (q1.size() != 0) chk("out1_data", {24'd0, o1d}, {24'd0, q1[0]});
        chk("cnt0", {16'd0, cnt0}, m0);
        chk("cnt1", {16'd0, cnt1}, m1);
        chk("cnt0_sat4", {28'd0, cnt0_s}, s0);
        chk("cnt1_sat4", {28'd0, cnt1_s}, s1);
    endtask

    task automatic model_step();
        logic acc;
        acc = in_valid && exp_ready();
        if (q0.size() != 0 && r0) begin
            void'(q0.pop_front());
            m0 = (m0 < 65535) ? m0 + 1 : m0;
            s0 = (s0 < 15) ? s0 + 1 : s0;
        end
        if (q1.size() != 0 && r1) begin
            void'(q1.pop_front());
            m1 = (m1 < 65535) ? m1 + 1 : m1;
            s1 = (s1 < 15) ? s1 + 1 : s1;
        end
        if (clr_cnt) begin
            m0 = 0; m1 = 0; s0 = 0; s1 = 0;
        end
        if (acc) begin
            if (in_sel) q1.push_back(in_data);
            else        q0.push_back(in_data);
        end
    endtask

    task automatic cycle();
        #1;
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic s, input logic [7:0] d,
                          input logic rr0, input logic rr1, input logic c);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        r0       = rr0;
        r1       = rr1;
        clr_cnt  = c;
    endtask

    initial begin
        // Basic route then out1 backpressure, expected values worked out by hand.
        //        v    sel   d      r0    r1    ir    ov0   od0    ov1   od1    c0 c1
        tbl[0] = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 0, 0};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 0, 0};
        tbl[2] = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1, 0};
        tbl[3] = '{1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h3C, 1, 0};
        tbl[4] = '{1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h3C, 1, 0};
        tbl[5] = '{1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C, 1, 0};
        tbl[6] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h5A, 1, 1};
        tbl[7] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1, 2};

        // Power-on reset state
        #12;
        chk("rst_out0_valid", {31'd0, o0v}, 0);
        chk("rst_out1_valid", {31'd0, o1v}, 0);
        chk("rst_out0_data", {24'd0, o0d}, 0);
        chk("rst_cnt0", {16'd0, cnt0}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            set_in(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].rr0, tbl[i].rr1, 1'b0);
            #1;
            chk($sformatf("tbl%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].ir});
            chk($sformatf("tbl%0d_out0_valid", i), {31'd0, o0v}, {31'd0, tbl[i].ov0});
            if (tbl[i].ov0) chk($sformatf("tbl%0d_out0_data", i), {24'd0, o0d}, {24'd0, tbl[i].od0});
            chk($sformatf("tbl%0d_out1_valid", i), {31'd0, o1v}, {31'd0, tbl[i].ov1});
            if (tbl[i].ov1) chk($sformatf("tbl%0d_out1_data", i), {24'd0, o1d}, {24'd0, tbl[i].od1});
            chk($sformatf("tbl%0d_cnt0", i), {16'd0, cnt0}, tbl[i].c0);
            chk($sformatf("tbl%0d_cnt1", i), {16'd0, cnt1}, tbl[i].c1);
            cycle();
        end

        // Isolation: out1 stalled on 8'h77 while 01..04 stream through out0
        set_in(1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        cycle();
        for (int i = 0; i <= 4; i++) begin
            set_in(i < 4, 1'b0, 8'(i + 1), 1'b1, 1'b0, 1'b0);
            #1;
            if (i < 4) chk("iso_in_ready", {31'd0, in_ready}, 1);
            if (i > 0) begin
                chk("iso_out0_valid", {31'd0, o0v}, 1);
                chk("iso_out0_data", {24'd0, o0d}, i);
            end
            chk("iso_out1_data", {24'd0, o1d}, 32'h77);
            cycle();
        end
        chk("iso_cnt1", {16'd0, cnt1}, 0);
        chk("iso_cnt0", {16'd0, cnt0}, 4);
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        cycle();
        cycle();

        // Interleave: alternating destinations, both consumers ready
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        cycle();
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 1'(i % 2), 8'(8'h10 + i), 1'b1, 1'b1, 1'b0);
            #1;
            chk("ilv_in_ready", {31'd0, in_ready}, 1);
            cycle();
        end
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        cycle();
        cycle();
        chk("ilv_cnt0", {16'd0, cnt0}, 4);
        chk("ilv_cnt1", {16'd0, cnt1}, 4);

        // Saturation on the 4-bit instance, then clear colliding with a handshake
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        cycle();
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 1'b0, 8'(i), 1'b1, 1'b0, 1'b0);
            cycle();
        end
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("sat_cnt0_s", {28'd0, cnt0_s}, 15);
        chk("sat_cnt0_wide", {16'd0, cnt0}, 20);
        set_in(1'b1, 1'b0, 8'hAA, 1'b1, 1'b0, 1'b0);
        cycle();
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        #1;
        chk("clr_hs_out0_valid", {31'd0, o0v}, 1);
        cycle();
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        #1;
        chk("clr_cnt0_s", {28'd0, cnt0_s}, 0);
        chk("clr_cnt0_wide", {16'd0, cnt0}, 0);
        cycle();

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom),
                   $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 63) == 0);
            cycle();
        end

        // Asynchronous reset mid-stream with a beat held in out1
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        cycle();
        cycle();
        set_in(1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
        cycle();
        set_in(1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        #1;
        chk("pre_rst_out1_valid", {31'd0, o1v}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out0_valid", {31'd0, o0v}, 0);
        chk("arst_out1_valid", {31'd0, o1v}, 0);
        chk("arst_out1_data", {24'd0, o1d}, 0);
        chk("arst_cnt0", {16'd0, cnt0}, 0);
        chk("arst_cnt1", {16'd0, cnt1}, 0);
        chk("arst_cnt1_s", {28'd0, cnt1_s}, 0);
        q0.delete();
        q1.delete();
        m0 = 0; m1 = 0; s0 = 0; s1 = 0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        set_in(1'b1, 1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
        cycle();
        set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
